// File: rtl/tile_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tile_array_ctrl
// Brief    : Layer sequencer for the tile array (weight load, fmap stream,
//            pipeline drain). Optional perf counters: TILE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tile_array_ctrl #(
    parameter int ROWS      = 5,
    parameter int T_ROWS    = 5,
    parameter int CNT_BW    = 16,
    parameter int ADDR_BW   = 12,
    parameter int DRAIN_LAT = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [2:0]         i_layer_state,
    input  logic [CNT_BW-1:0]  i_num_cols,
    input  logic [CNT_BW-1:0]  i_num_pass,
    input  logic               i_stall,
    input  logic               i_abort,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_w_rd_en,
    output logic [ADDR_BW-1:0] o_w_addr,
    output logic               o_f_rd_en,
    output logic [ADDR_BW-1:0] o_f_addr,
    output logic               o_en_tf,
    output logic [1:0]         o_cal_state,
    output logic [2:0]         o_layer_state,
    output logic               o_acc_valid,
    output logic [31:0]        o_cycle_cnt,
    output logic [31:0]        o_stall_cnt
);

    localparam int c_LOAD_BEATS = ROWS * T_ROWS;
    localparam int c_LD_W       = $clog2(c_LOAD_BEATS + 1);
    localparam int c_DR_W       = $clog2(DRAIN_LAT + 1);
    localparam logic [c_LD_W-1:0] c_LOAD_LAST  = c_LD_W'(c_LOAD_BEATS - 1);
    localparam logic [c_DR_W-1:0] c_DRAIN_LAST = c_DR_W'(DRAIN_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_layer;
    logic [CNT_BW-1:0]    r_num_cols;
    logic [CNT_BW-1:0]    r_num_pass;
    logic [CNT_BW-1:0]    r_pass_cnt;
    logic [c_LD_W-1:0]    r_load_cnt;
    logic [ADDR_BW-1:0]   r_w_addr;
    logic [CNT_BW-1:0]    r_col_cnt;
    logic [c_DR_W-1:0]    r_drain_cnt;
    logic                 r_en_tf;
    logic [1:0]           r_cal_state;
    logic [DRAIN_LAT-1:0] r_acc_sr;

    logic                 w_abort;
    logic                 w_accept;
    logic                 w_zero_cmd;
    logic                 w_w_issue;
    logic                 w_f_issue;
    logic                 w_col_last;
    logic                 w_drain_last;
    logic                 w_more_pass;
    logic [CNT_BW-1:0]    w_pass_inc;
    logic [1:0]           w_cal_src;

    assign w_abort      = i_abort && (r_state != S_IDLE);
    assign w_zero_cmd   = (i_num_cols == '0) || (i_num_pass == '0);
    assign w_col_last   = (r_col_cnt == r_num_cols - CNT_BW'(1));
    assign w_drain_last = (r_drain_cnt == c_DRAIN_LAST);
    assign w_pass_inc   = r_pass_cnt + CNT_BW'(1);
    assign w_more_pass  = (w_pass_inc < r_num_pass);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort wins over stall and every transition, and also masks the strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_w_issue   = 1'b0;
        w_f_issue   = 1'b0;
        w_cal_src   = 2'b00;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_accept    = 1'b1;
                        w_state_nxt = w_zero_cmd ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_cal_src = 2'b01;
                    if (!i_stall) begin
                        w_w_issue = 1'b1;
                        if (r_load_cnt == c_LOAD_LAST) begin
                            w_state_nxt = S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    w_cal_src = 2'b10;
                    if (!i_stall) begin
                        w_f_issue = 1'b1;
                        if (w_col_last) begin
                            w_state_nxt = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    w_cal_src = 2'b11;
                    if (w_drain_last) begin
                        w_state_nxt = w_more_pass ? S_LOAD : S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer     <= '0;
            r_num_cols  <= '0;
            r_num_pass  <= '0;
            r_pass_cnt  <= '0;
            r_load_cnt  <= '0;
            r_w_addr    <= '0;
            r_col_cnt   <= '0;
            r_drain_cnt <= '0;
            r_en_tf     <= 1'b0;
            r_cal_state <= 2'b00;
            r_acc_sr    <= '0;
        end else begin
            // One-register delay matches the buffer read latency.
            r_en_tf     <= w_w_issue;
            r_cal_state <= w_cal_src;
            if (w_abort) begin
                r_acc_sr <= '0;
            end else begin
                r_acc_sr[0] <= w_f_issue;
                for (int i = 1; i < DRAIN_LAT; i++) begin
                    r_acc_sr[i] <= r_acc_sr[i-1];
                end
            end
            if (w_abort || w_accept) begin
                r_pass_cnt  <= '0;
                r_load_cnt  <= '0;
                r_w_addr    <= '0;
                r_col_cnt   <= '0;
                r_drain_cnt <= '0;
            end
            if (w_accept && !w_zero_cmd) begin
                r_layer    <= i_layer_state;
                r_num_cols <= i_num_cols;
                r_num_pass <= i_num_pass;
            end
            if (w_w_issue) begin
                r_w_addr   <= r_w_addr + ADDR_BW'(1);
                r_load_cnt <= (r_load_cnt == c_LOAD_LAST) ? '0 : r_load_cnt + c_LD_W'(1);
            end
            if (w_f_issue) begin
                r_col_cnt <= w_col_last ? '0 : r_col_cnt + CNT_BW'(1);
            end
            if ((r_state == S_DRAIN) && !w_abort) begin
                if (w_drain_last) begin
                    r_drain_cnt <= '0;
                    if (w_more_pass) begin
                        r_pass_cnt <= w_pass_inc;
                    end
                end else begin
                    r_drain_cnt <= r_drain_cnt + c_DR_W'(1);
                end
            end
        end
    end

`ifdef TILE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || ((r_state == S_IDLE) && i_start)) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (i_stall && ((r_state == S_LOAD) || (r_state == S_COMPUTE))
                && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_cycle_cnt = '0;
    assign o_stall_cnt = '0;
`endif

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_w_rd_en     = w_w_issue;
    assign o_w_addr      = r_w_addr;
    assign o_f_rd_en     = w_f_issue;
    assign o_f_addr      = ADDR_BW'(r_col_cnt);
    assign o_en_tf       = r_en_tf;
    assign o_cal_state   = r_cal_state;
    assign o_layer_state = r_layer;
    assign o_acc_valid   = r_acc_sr[DRAIN_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_tile_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_array_ctrl
// Brief    : Self-checking bench for tile_array_ctrl (schedule-queue model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_array_ctrl;

    localparam int ROWS       = 5;
    localparam int T_ROWS     = 5;
    localparam int CNT_BW     = 16;
    localparam int ADDR_BW    = 12;
    localparam int DRAIN_LAT  = 10;
    localparam int LOAD_BEATS = ROWS * T_ROWS;
    localparam int K_IDLE = 0, K_LOAD = 1, K_COMP = 2, K_DRAIN = 3, K_DONE = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_start;
    logic [2:0]         i_layer_state;
    logic [CNT_BW-1:0]  i_num_cols;
    logic [CNT_BW-1:0]  i_num_pass;
    logic               i_stall;
    logic               i_abort;
    logic               o_busy;
    logic               o_done;
    logic               o_w_rd_en;
    logic [ADDR_BW-1:0] o_w_addr;
    logic               o_f_rd_en;
    logic [ADDR_BW-1:0] o_f_addr;
    logic               o_en_tf;
    logic [1:0]         o_cal_state;
    logic [2:0]         o_layer_state;
    logic               o_acc_valid;
    logic [31:0]        o_cycle_cnt;
    logic [31:0]        o_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tile_array_ctrl #(
        .ROWS(ROWS), .T_ROWS(T_ROWS), .CNT_BW(CNT_BW),
        .ADDR_BW(ADDR_BW), .DRAIN_LAT(DRAIN_LAT)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_layer_state(i_layer_state),
        .i_num_cols(i_num_cols), .i_num_pass(i_num_pass), .i_stall(i_stall),
        .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_w_rd_en(o_w_rd_en),
        .o_w_addr(o_w_addr), .o_f_rd_en(o_f_rd_en), .o_f_addr(o_f_addr),
        .o_en_tf(o_en_tf), .o_cal_state(o_cal_state), .o_layer_state(o_layer_state),
        .o_acc_valid(o_acc_valid), .o_cycle_cnt(o_cycle_cnt), .o_stall_cnt(o_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: on accept, the whole command is expanded into a per-cycle schedule
    // of phases; a stalled LOAD/COMPUTE cycle simply does not consume its entry.
    typedef struct { int kind; int addr; } item_t;
    item_t       sched[$];
    int          fbeats[$];
    int          tcyc      = 0;
    int          m_wbeats  = 0;
    logic [31:0] m_cyc     = 0;
    logic [31:0] m_stl     = 0;
    logic [2:0]  m_layer   = 0;
    bit          m_prev_w  = 0;
    logic [1:0]  m_prev_cal = 0;
    bit          armed     = 0;

    always @(negedge clk) begin
        int kind;
        bit busy, stallable, e_w, e_f, e_acc;
        logic [1:0] cal_src;
        int f_addr;
        busy      = (sched.size() != 0);
        kind      = busy ? sched[0].kind : K_IDLE;
        stallable = (kind == K_LOAD) || (kind == K_COMP);
        e_w       = (kind == K_LOAD) && !i_stall && !i_abort;
        e_f       = (kind == K_COMP) && !i_stall && !i_abort;
        f_addr    = (kind == K_COMP) ? sched[0].addr : 0;
        e_acc     = 1'b0;
        if (fbeats.size() != 0 && fbeats[0] == tcyc - DRAIN_LAT) begin
            e_acc = 1'b1;
            void'(fbeats.pop_front());
        end
        case (kind)
            K_LOAD:  cal_src = 2'b01;
            K_COMP:  cal_src = 2'b10;
            K_DRAIN: cal_src = 2'b11;
            default: cal_src = 2'b00;
        endcase
        if (busy && i_abort) cal_src = 2'b00;

        if (armed) begin
            chk("busy",      o_busy,        busy);
            chk("done",      o_done,        kind == K_DONE);
            chk("w_rd_en",   o_w_rd_en,     e_w);
            chk("w_addr",    o_w_addr,      m_wbeats % (1 << ADDR_BW));
            chk("f_rd_en",   o_f_rd_en,     e_f);
            chk("f_addr",    o_f_addr,      f_addr);
            chk("en_tf",     o_en_tf,       m_prev_w);
            chk("cal_state", o_cal_state,   m_prev_cal);
            chk("layer",     o_layer_state, m_layer);
            chk("acc_valid", o_acc_valid,   e_acc);
`ifdef TILE_CTRL_PERF_EN
            chk("cycle_cnt", o_cycle_cnt,   m_cyc);
            chk("stall_cnt", o_stall_cnt,   m_stl);
`else
            chk("cycle_cnt", o_cycle_cnt,   0);
            chk("stall_cnt", o_stall_cnt,   0);
`endif
        end

        if (rst) begin
            sched.delete();
            fbeats.delete();
            m_wbeats = 0; m_cyc = 0; m_stl = 0; m_layer = 0;
            m_prev_w = 0; m_prev_cal = 0;
            armed = 1;
        end else begin
            if (busy && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (stallable && i_stall && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
            if (e_w) m_wbeats++;
            if (e_f) fbeats.push_back(tcyc);
            m_prev_w   = e_w;
            m_prev_cal = cal_src;
            if (busy && i_abort) begin
                sched.delete();
                fbeats.delete();
                m_wbeats = 0;
            end else if (!busy && i_start) begin
                m_wbeats = 0; m_cyc = 0; m_stl = 0;
                if (i_num_cols != 0 && i_num_pass != 0) begin
                    for (int p = 0; p < int'(i_num_pass); p++) begin
                        for (int b = 0; b < LOAD_BEATS; b++) sched.push_back('{K_LOAD, p * LOAD_BEATS + b});
                        for (int c = 0; c < int'(i_num_cols); c++) sched.push_back('{K_COMP, c});
                        for (int d = 0; d < DRAIN_LAT; d++) sched.push_back('{K_DRAIN, 0});
                    end
                    m_layer = i_layer_state;
                end
                sched.push_back('{K_DONE, 0});
            end else if (busy && !(stallable && i_stall)) begin
                void'(sched.pop_front());
            end
        end
        tcyc++;
    end

    // Runs one command from the current cycle (cycle 0 = start sampled) until idle.
    task automatic run_cmd(input int cols, input int npass, input logic [2:0] layer,
                           input int st_from, input int st_len, input int busy_start_at,
                           output int done_cyc, output int beats, output int first_acc,
                           output int w_max, output int n_w, output int n_f);
        int cyc;
        bit timed_out;
        done_cyc = -1; beats = 0; first_acc = -1; w_max = -1; n_w = 0; n_f = 0;
        timed_out = 0;
        i_num_cols = CNT_BW'(cols); i_num_pass = CNT_BW'(npass);
        i_layer_state = layer; i_start = 1'b1;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            i_start = (cyc == busy_start_at);
            if (cyc == busy_start_at) i_num_cols = 16'd3;
            i_stall = (cyc >= st_from) && (cyc < st_from + st_len);
            #1;
            if (o_acc_valid) begin
                beats++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (o_w_rd_en) begin
                n_w++;
                if (int'(o_w_addr) > w_max) w_max = int'(o_w_addr);
            end
            if (o_f_rd_en) n_f++;
            if (o_done && done_cyc < 0) done_cyc = cyc;
            if (!o_busy) break;
            if (cyc > 2000) begin timed_out = 1; break; end
        end
        i_stall = 1'b0;
        i_start = 1'b0;
        chk("cmd_completes", timed_out, 0);
        chk("idle_after_done", cyc, done_cyc + 1);
    endtask

    initial begin
        int dc, bt, fa, wm, nw, nf, cyc;
        bit seen_done;
        rst = 1; i_start = 0; i_layer_state = 0; i_num_cols = 0; i_num_pass = 0;
        i_stall = 0; i_abort = 0;
        repeat (3) @(posedge clk);
        #1; rst = 0; #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_cal", o_cal_state, 0);
        chk("rst_waddr", o_w_addr, 0);
        chk("rst_acc", o_acc_valid, 0);

        // Single pass, with a start pulse mid-LOAD that must be ignored
        run_cmd(8, 1, 3'd3, 0, 0, 10, dc, bt, fa, wm, nw, nf);
        chk("single_done_cyc", dc, 44);
        chk("single_beats", bt, 8);
        chk("single_first_acc", fa, 36);
        chk("single_w_max", wm, 24);
        chk("single_n_w", nw, 25);
        chk("single_n_f", nf, 8);
        chk("single_layer", o_layer_state, 3);
`ifdef TILE_CTRL_PERF_EN
        chk("single_cycle_cnt", o_cycle_cnt, 44);
`endif

        // Three passes
        run_cmd(4, 3, 3'd5, 0, 0, -1, dc, bt, fa, wm, nw, nf);
        chk("three_done_cyc", dc, 118);
        chk("three_beats", bt, 12);
        chk("three_w_max", wm, 74);
        chk("three_n_w", nw, 75);
        chk("three_n_f", nf, 12);

        // Stall for 3 cycles mid-COMPUTE
        run_cmd(8, 1, 3'd2, 28, 3, -1, dc, bt, fa, wm, nw, nf);
        chk("stall_done_cyc", dc, 47);
        chk("stall_beats", bt, 8);
`ifdef TILE_CTRL_PERF_EN
        chk("stall_cnt_val", o_stall_cnt, 3);
`else
        chk("stall_cnt_tied", o_stall_cnt, 0);
`endif

        // Zero column count
        run_cmd(0, 2, 3'd6, 0, 0, -1, dc, bt, fa, wm, nw, nf);
        chk("zero_done_cyc", dc, 1);
        chk("zero_n_w", nw, 0);
        chk("zero_n_f", nf, 0);

        // Abort during DRAIN, then a new start one cycle later
        i_num_cols = 16'd8; i_num_pass = 16'd1; i_layer_state = 3'd1; i_start = 1;
        for (int k = 1; k <= 38; k++) begin
            @(posedge clk); #1;
            i_start = 0;
            i_abort = (k == 38);
        end
        @(posedge clk); #1;
        i_abort = 0;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_acc", o_acc_valid, 0);
        chk("abort_done", o_done, 0);
        i_num_cols = 16'd2; i_start = 1;
        @(posedge clk); #1;
        i_start = 0;
        #1;
        chk("restart_busy", o_busy, 1);
        cyc = 1; seen_done = 0;
        while (o_busy && cyc < 500) begin
            @(posedge clk); #2;
            cyc++;
            if (o_done) begin
                seen_done = 1;
                chk("restart_done_cyc", cyc, 38);
            end
        end
        chk("restart_saw_done", seen_done, 1);

        // Reset mid-COMPUTE
        i_num_cols = 16'd8; i_num_pass = 16'd1; i_layer_state = 3'd7; i_start = 1;
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk); #1;
            i_start = 0;
            rst = (k == 28);
        end
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("mrst_busy", o_busy, 0);
        chk("mrst_frd", o_f_rd_en, 0);
        chk("mrst_faddr", o_f_addr, 0);
        chk("mrst_waddr", o_w_addr, 0);
        chk("mrst_entf", o_en_tf, 0);
        chk("mrst_cal", o_cal_state, 0);
        chk("mrst_layer", o_layer_state, 0);
        chk("mrst_acc", o_acc_valid, 0);
        chk("mrst_cyc", o_cycle_cnt, 0);

        // Randomized traffic checked cycle-by-cycle against the model
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            i_stall = ($urandom_range(0, 4) == 0);
            i_abort = ($urandom_range(0, 199) == 0);
            i_start = ($urandom_range(0, 5) == 0);
            rst     = ($urandom_range(0, 1499) == 0);
            if (i_start) begin
                i_num_cols    = CNT_BW'($urandom_range(0, 9));
                i_num_pass    = CNT_BW'($urandom_range(0, 3));
                i_layer_state = 3'($urandom);
            end
        end
        @(posedge clk); #1;
        i_stall = 0; i_abort = 0; i_start = 0; rst = 0;
        repeat (5) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
